// File: rtl/keycode_cmd_filter.sv
// Converts per-frame USB HID keycode samples into direction commands with press, auto-repeat,
// release and jump pulses. Frame timing comes from a synchronised VGA vsync falling edge.
module keycode_cmd_filter #(
  parameter int unsigned REPEAT_DELAY = 15,
  parameter int unsigned REPEAT_RATE  = 4
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [15:0] Keycode,
  input  logic        frame_vs,
  output logic        frame_tick,
  output logic [3:0]  cur_dir,
  output logic        cmd_valid,
  output logic [3:0]  cmd_dir,
  output logic        release_pulse,
  output logic        jump_pulse,
  output logic [7:0]  held_frames
);

  typedef enum logic [1:0] {IDLE, PRESS, DELAY, REPEAT} state_t;

  localparam logic [7:0] DELAY_LIM = 8'(REPEAT_DELAY);
  localparam logic [7:0] RATE_LIM  = 8'(REPEAT_RATE);
  localparam logic [7:0] KEY_SPACE = 8'h2C;

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt, cnt_inc;
  logic [7:0] held_nxt;
  logic       emit, rel;
  logic       vs_s1, vs_s2, vs_s3;
  logic       prev_space, space_now;
  logic [3:0] dir0, dir1, dir;

  function automatic logic [3:0] decode(input logic [7:0] k);
    case (k)
      8'h1A:   decode = 4'b1000;
      8'h16:   decode = 4'b0100;
      8'h04:   decode = 4'b0010;
      8'h07:   decode = 4'b0001;
      default: decode = 4'b0000;
    endcase
  endfunction

  always_comb begin
    dir0      = decode(Keycode[7:0]);
    dir1      = decode(Keycode[15:8]);
    dir       = (dir0 != 4'b0000) ? dir0 : dir1;
    space_now = (Keycode[7:0] == KEY_SPACE) || (Keycode[15:8] == KEY_SPACE);
  end

  // Next state is only committed on frame_tick; cur_dir holds the previous frame's direction.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    held_nxt  = held_frames;
    cnt_inc   = cnt + 8'd1;
    emit      = 1'b0;
    rel       = 1'b0;
    if (state == IDLE) begin
      if (dir != 4'b0000) begin
        state_nxt = PRESS;
        emit      = 1'b1;
        cnt_nxt   = '0;
        held_nxt  = '0;
      end
    end else if (dir == 4'b0000) begin
      state_nxt = IDLE;
      rel       = 1'b1;
      cnt_nxt   = '0;
      held_nxt  = '0;
    end else if (dir != cur_dir) begin
      state_nxt = PRESS;
      emit      = 1'b1;
      cnt_nxt   = '0;
      held_nxt  = '0;
    end else begin
      held_nxt = (held_frames == 8'hFF) ? 8'hFF : held_frames + 8'd1;
      case (state)
        PRESS: begin
          state_nxt = DELAY;
          cnt_nxt   = 8'd1;
        end
        // First repeat fires REPEAT_DELAY+2 frames after the press (frame 17 with defaults).
        DELAY: begin
          if (cnt >= DELAY_LIM) begin
            state_nxt = REPEAT;
            emit      = 1'b1;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        REPEAT: begin
          if (cnt_inc >= RATE_LIM) begin
            emit    = 1'b1;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else if (frame_tick) state <= state_nxt;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vs_s1         <= 1'b1;
      vs_s2         <= 1'b1;
      vs_s3         <= 1'b1;
      frame_tick    <= 1'b0;
      cnt           <= '0;
      cur_dir       <= '0;
      cmd_valid     <= 1'b0;
      cmd_dir       <= '0;
      release_pulse <= 1'b0;
      jump_pulse    <= 1'b0;
      held_frames   <= '0;
      prev_space    <= 1'b0;
    end else begin
      vs_s1         <= frame_vs;
      vs_s2         <= vs_s1;
      vs_s3         <= vs_s2;
      frame_tick    <= vs_s3 & ~vs_s2;
      cmd_valid     <= 1'b0;
      release_pulse <= 1'b0;
      jump_pulse    <= 1'b0;
      if (frame_tick) begin
        cnt           <= cnt_nxt;
        cur_dir       <= dir;
        cmd_valid     <= emit;
        release_pulse <= rel;
        jump_pulse    <= space_now & ~prev_space;
        held_frames   <= held_nxt;
        prev_space    <= space_now;
        if (emit) cmd_dir <= dir;
      end
    end
  end

endmodule

// File: tb/tb_keycode_cmd_filter.sv
// Scoreboard bench for keycode_cmd_filter: each frame pushes the expected eval-cycle outputs,
// a monitor pops and compares on every eval cycle and checks outputs stay quiet in between.
module tb_keycode_cmd_filter;

  typedef struct packed {
    logic       cv;
    logic [3:0] cmd;
    logic [3:0] cur;
    logic       rel;
    logic       jmp;
    logic [7:0] held;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] keycode = '0;
  logic        frame_vs = 1'b1;
  logic        frame_tick, cmd_valid, release_pulse, jump_pulse;
  logic [3:0]  cur_dir, cmd_dir;
  logic [7:0]  held_frames;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  exp_t        exp_q[$];
  exp_t        last = '0;
  logic        tick_seen = 1'b0;

  keycode_cmd_filter #(.REPEAT_DELAY(15), .REPEAT_RATE(4)) dut (
    .Clk(clk), .Reset_n(rst_n), .Keycode(keycode), .frame_vs(frame_vs),
    .frame_tick(frame_tick), .cur_dir(cur_dir), .cmd_valid(cmd_valid), .cmd_dir(cmd_dir),
    .release_pulse(release_pulse), .jump_pulse(jump_pulse), .held_frames(held_frames)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic cv, input logic [3:0] cmd, input logic [3:0] cur,
                              input logic rel, input logic jmp, input logic [7:0] held);
    mk = '{cv, cmd, cur, rel, jmp, held};
  endfunction

  // Monitor: the cycle after frame_tick is the eval cycle.
  always @(negedge clk) begin
    exp_t act, e;
    act = '{cmd_valid, cmd_dir, cur_dir, release_pulse, jump_pulse, held_frames};
    if (!rst_n) begin
      last      = '0;
      tick_seen = 1'b0;
    end else begin
      if (tick_seen) begin
        if (exp_q.size() == 0) begin
          chk("eval_unexpected", 32'(act), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("eval_outputs", 32'(act), 32'(e));
          last = e;
        end
      end else begin
        chk("between_frames", 32'(act), 32'(mk(1'b0, last.cmd, last.cur, 1'b0, 1'b0, last.held)));
      end
      tick_seen = frame_tick;
    end
  end

  // One frame: apply kc, drop vsync, check tick latency, optionally disturb Keycode mid-frame.
  task automatic frame(input logic [15:0] kc, input exp_t e, input logic use_mid,
                       input logic [15:0] mid);
    int unsigned k;
    keycode = kc;
    exp_q.push_back(e);
    @(posedge clk); #1;
    frame_vs = 1'b0;
    k = 0;
    while (!frame_tick && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    chk("tick_latency", k, 3);
    @(posedge clk); #1;
    frame_vs = 1'b1;
    if (use_mid) keycode = mid;
    repeat (5) @(posedge clk);
  endtask

  task automatic hold_frames(input logic [15:0] kc, input logic [3:0] d, input int unsigned n,
                             input logic use_mid);
    for (int unsigned f = 1; f <= n; f++) begin
      logic cv;
      cv = (f == 1) || (f == 17) || (f >= 21 && ((f - 21) % 4) == 0);
      frame(kc, mk(cv, d, d, 1'b0, 1'b0, (f > 256) ? 8'd255 : 8'(f - 1)), use_mid, 16'h0016);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 32'({frame_tick, cur_dir, cmd_valid, cmd_dir, release_pulse, jump_pulse, held_frames}), 0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Single press of W then release
    frame(16'h001A, mk(1, 4'b1000, 4'b1000, 0, 0, 8'd0), 0, 0);
    frame(16'h0000, mk(0, 4'b1000, 4'b0000, 1, 0, 8'd0), 0, 0);

    // Hold D for 30 frames: commands on 1, 17, 21, 25, 29
    hold_frames(16'h0007, 4'b0001, 30, 1'b0);
    frame(16'h0000, mk(0, 4'b0001, 4'b0000, 1, 0, 8'd0), 0, 0);

    // Slot priority, new press from slot1, release
    frame(16'h1604, mk(1, 4'b0010, 4'b0010, 0, 0, 8'd0), 0, 0);
    frame(16'h1600, mk(1, 4'b0100, 4'b0100, 0, 0, 8'd0), 0, 0);
    frame(16'h0000, mk(0, 4'b0100, 4'b0000, 1, 0, 8'd0), 0, 0);

    // Space with direction, held, re-pressed, alone, idle-to-idle
    frame(16'h2C1A, mk(1, 4'b1000, 4'b1000, 0, 1, 8'd0), 0, 0);
    frame(16'h2C1A, mk(0, 4'b1000, 4'b1000, 0, 0, 8'd1), 0, 0);
    frame(16'h2C1A, mk(0, 4'b1000, 4'b1000, 0, 0, 8'd2), 0, 0);
    frame(16'h001A, mk(0, 4'b1000, 4'b1000, 0, 0, 8'd3), 0, 0);
    frame(16'h2C1A, mk(0, 4'b1000, 4'b1000, 0, 1, 8'd4), 0, 0);
    frame(16'h0000, mk(0, 4'b1000, 4'b0000, 1, 0, 8'd0), 0, 0);
    frame(16'h002C, mk(0, 4'b1000, 4'b0000, 0, 1, 8'd0), 0, 0);
    frame(16'h0000, mk(0, 4'b1000, 4'b0000, 0, 0, 8'd0), 0, 0);

    // Hold A for 300 frames with a mid-frame Keycode disturbance; held_frames saturates
    hold_frames(16'h0004, 4'b0010, 300, 1'b1);
    frame(16'h0000, mk(0, 4'b0010, 4'b0000, 1, 0, 8'd0), 0, 0);

    // Reset during REPEAT with S held, then re-press after release
    hold_frames(16'h0016, 4'b0100, 19, 1'b0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("reset_midrepeat", 32'({cur_dir, cmd_valid, cmd_dir, release_pulse, jump_pulse, held_frames}), 0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    frame(16'h0016, mk(1, 4'b0100, 4'b0100, 0, 0, 8'd0), 0, 0);
    frame(16'h0016, mk(0, 4'b0100, 4'b0100, 0, 0, 8'd1), 0, 0);
    frame(16'h0000, mk(0, 4'b0100, 4'b0000, 1, 0, 8'd0), 0, 0);

    repeat (5) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
